// File: rtl/pong_frame_renderer.sv
// Pong renderer: registered RGB per pixel plus a once-per-frame game-state update on the Y=480 tick.
// Optional dashed centre net is enabled by defining PONG_NET_EN.
module pong_frame_renderer #(
   parameter int unsigned BallSpeed   = 4,
   parameter int unsigned PaddleSpeed = 6,
   parameter int unsigned PaddleH     = 64,
   parameter int unsigned ServeFrames = 60,
   parameter int unsigned WinScore    = 7
) (
   input  logic       PixelClock,
   input  logic       Reset,
   input  logic [9:0] Xpixel,
   input  logic [9:0] Ypixel,
   input  logic       displayON,
   input  logic       P1Up,
   input  logic       P1Down,
   input  logic       P2Up,
   input  logic       P2Down,
   output logic [2:0] Red,
   output logic [2:0] Green,
   output logic [2:0] Blue,
   output logic [3:0] Score1,
   output logic [3:0] Score2,
   output logic       GameOver
);

   localparam logic signed [10:0] BallStep  = 11'(BallSpeed);
   localparam logic signed [10:0] PadStep   = 11'(PaddleSpeed);
   localparam logic signed [10:0] PadHs     = 11'(PaddleH);
   localparam logic signed [10:0] PadMax    = 11'(480 - PaddleH);
   localparam logic [9:0]         PadInit   = 10'((480 - PaddleH) / 2);
   localparam logic [9:0]         BallX0    = 10'd316;
   localparam logic [9:0]         BallY0    = 10'd236;
   localparam logic [7:0]         ServeLast = 8'(ServeFrames - 1);
   localparam logic [7:0]         PointLast = 8'd29;
   localparam logic [3:0]         WinS      = 4'(WinScore);
   localparam logic [10:0]        PadHu     = 11'(PaddleH);

   typedef enum logic [1:0] {StServe, StPlay, StPoint, StOver} state_e;

   state_e     state_q, state_d;
   logic       y480_q, y480_d;
   logic       tick_q, tick_d;
   logic [7:0] cnt_q, cnt_d;
   logic [9:0] ball_x_q, ball_x_d;
   logic [9:0] ball_y_q, ball_y_d;
   logic       dx_q, dx_d;
   logic       dy_q, dy_d;
   logic [9:0] p1_y_q, p1_y_d;
   logic [9:0] p2_y_q, p2_y_d;
   logic [3:0] score1_q, score1_d;
   logic [3:0] score2_q, score2_d;
   logic [8:0] rgb_q, rgb_d;

   logic signed [10:0] bx_s, by_s, p1_s, p2_s, nx_s, ny_s;
   logic               ov1, ov2, pt1, pt2;
   logic [9:0]         play_x, play_y;
   logic               play_dx, play_dy;

   function automatic logic [9:0] pad_next(input logic [9:0] y, input logic up, input logic dn);
      logic signed [10:0] t;
      t = signed'({1'b0, y});
      if (up && !dn) begin
         t = t - PadStep;
      end else if (dn && !up) begin
         t = t + PadStep;
      end
      if (t < 11'sd0) begin
         t = 11'sd0;
      end else if (t > PadMax) begin
         t = PadMax;
      end
      return t[9:0];
   endfunction

   // Ball motion for one PLAY tick; collisions use the paddle positions before this tick's move.
   always_comb begin
      bx_s    = signed'({1'b0, ball_x_q});
      by_s    = signed'({1'b0, ball_y_q});
      p1_s    = signed'({1'b0, p1_y_q});
      p2_s    = signed'({1'b0, p2_y_q});
      ov1     = (by_s + 11'sd8 > p1_s) && (by_s < p1_s + PadHs);
      ov2     = (by_s + 11'sd8 > p2_s) && (by_s < p2_s + PadHs);
      ny_s    = dy_q ? (by_s + BallStep) : (by_s - BallStep);
      nx_s    = dx_q ? (bx_s + BallStep) : (bx_s - BallStep);
      play_x  = ball_x_q;
      play_y  = ball_y_q;
      play_dx = dx_q;
      play_dy = dy_q;
      pt1     = 1'b0;
      pt2     = 1'b0;

      if (ny_s <= 11'sd0) begin
         play_y  = 10'd0;
         play_dy = 1'b1;
      end else if (ny_s >= 11'sd472) begin
         play_y  = 10'd472;
         play_dy = 1'b0;
      end else begin
         play_y = ny_s[9:0];
      end

      if (!dx_q) begin
         if (bx_s >= 11'sd24 && nx_s <= 11'sd24 && ov1) begin
            play_x  = 10'd24;
            play_dx = 1'b1;
         end else if (nx_s <= 11'sd0) begin
            pt2 = 1'b1;
         end else begin
            play_x = nx_s[9:0];
         end
      end else begin
         if (bx_s <= 11'sd608 && nx_s >= 11'sd608 && ov2) begin
            play_x  = 10'd608;
            play_dx = 1'b0;
         end else if (nx_s >= 11'sd632) begin
            pt1 = 1'b1;
         end else begin
            play_x = nx_s[9:0];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ball_x_d = ball_x_q;
      ball_y_d = ball_y_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      p1_y_d   = p1_y_q;
      p2_y_d   = p2_y_q;
      score1_d = score1_q;
      score2_d = score2_q;
      y480_d   = (Ypixel == 10'd480);
      tick_d   = y480_d && !y480_q;

      if (tick_q) begin
         unique case (state_q)
            StServe: begin
               if (cnt_q == ServeLast) begin
                  state_d = StPlay;
                  cnt_d   = 8'd0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            StPlay: begin
               if (pt1 || pt2) begin
                  // Ball stays where it left; next serve heads toward the player who conceded.
                  state_d = StPoint;
                  cnt_d   = 8'd0;
                  if (pt1) begin
                     dx_d = 1'b1;
                     if (score1_q < WinS) score1_d = score1_q + 4'd1;
                  end else begin
                     dx_d = 1'b0;
                     if (score2_q < WinS) score2_d = score2_q + 4'd1;
                  end
               end else begin
                  ball_x_d = play_x;
                  ball_y_d = play_y;
                  dx_d     = play_dx;
                  dy_d     = play_dy;
               end
            end
            StPoint: begin
               if (cnt_q == PointLast) begin
                  cnt_d = 8'd0;
                  if (score1_q == WinS || score2_q == WinS) begin
                     state_d = StOver;
                  end else begin
                     state_d  = StServe;
                     ball_x_d = BallX0;
                     ball_y_d = BallY0;
                  end
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            default: ;
         endcase

         if (state_q == StServe || state_q == StPlay) begin
            p1_y_d = pad_next(p1_y_q, P1Up, P1Down);
            p2_y_d = pad_next(p2_y_q, P2Up, P2Down);
         end
      end
   end

   logic [10:0] xp, yp;
   logic        on_ball, on_pad, on_net;

   always_comb begin
      xp      = {1'b0, Xpixel};
      yp      = {1'b0, Ypixel};
      on_ball = (xp >= {1'b0, ball_x_q}) && (xp < {1'b0, ball_x_q} + 11'd8) &&
                (yp >= {1'b0, ball_y_q}) && (yp < {1'b0, ball_y_q} + 11'd8);
      on_pad  = ((xp >= 11'd16) && (xp <= 11'd23) &&
                 (yp >= {1'b0, p1_y_q}) && (yp < {1'b0, p1_y_q} + PadHu)) ||
                ((xp >= 11'd616) && (xp <= 11'd623) &&
                 (yp >= {1'b0, p2_y_q}) && (yp < {1'b0, p2_y_q} + PadHu));
`ifdef PONG_NET_EN
      on_net  = (xp >= 11'd318) && (xp <= 11'd321) && !Ypixel[4];
`else
      on_net  = 1'b0;
`endif
      rgb_d   = 9'd0;
      if (!displayON) begin
         rgb_d = 9'd0;
      end else if (on_ball || on_pad) begin
         rgb_d = {3'd7, 3'd7, 3'd7};
      end else if (on_net) begin
         rgb_d = {3'd3, 3'd3, 3'd3};
      end else if (state_q == StOver) begin
         rgb_d = {3'd2, 3'd0, 3'd0};
      end
   end

   always_ff @(posedge PixelClock or posedge Reset) begin
      if (Reset) begin
         state_q  <= StServe;
         y480_q   <= 1'b0;
         tick_q   <= 1'b0;
         cnt_q    <= 8'd0;
         ball_x_q <= BallX0;
         ball_y_q <= BallY0;
         dx_q     <= 1'b1;
         dy_q     <= 1'b1;
         p1_y_q   <= PadInit;
         p2_y_q   <= PadInit;
         score1_q <= 4'd0;
         score2_q <= 4'd0;
         rgb_q    <= 9'd0;
      end else begin
         state_q  <= state_d;
         y480_q   <= y480_d;
         tick_q   <= tick_d;
         cnt_q    <= cnt_d;
         ball_x_q <= ball_x_d;
         ball_y_q <= ball_y_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         p1_y_q   <= p1_y_d;
         p2_y_q   <= p2_y_d;
         score1_q <= score1_d;
         score2_q <= score2_d;
         rgb_q    <= rgb_d;
      end
   end

   assign Red      = rgb_q[8:6];
   assign Green    = rgb_q[5:3];
   assign Blue     = rgb_q[2:0];
   assign Score1   = score1_q;
   assign Score2   = score2_q;
   assign GameOver = (state_q == StOver);

endmodule
